// File: rtl/serial_word_receiver.sv
// Receiver for the phase-tag serial link: oversamples serial clock, data and frame
// line in the sys_clk domain, rebuilds each MSB-first word and offers it on valid/ready.
module serial_word_receiver #(
  parameter int phase_count_size = 16,
  parameter int sync_stages      = 2
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic                        serial_clk,
  input  logic                        serial_in,
  input  logic                        serial_valid,
  output logic [phase_count_size-1:0] word,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic                        frame_error,
  output logic                        overrun,
  output logic [15:0]                 frame_count,
  output logic [1:0]                  fsm_state
);

  localparam int W  = phase_count_size;
  localparam int CW = $clog2(phase_count_size) + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_END = 2'd2
  } state_t;

  // Input synchronizers. All three lines see the same depth so their relative
  // timing survives; reset puts them at link-idle levels.
  logic [sync_stages-1:0] clk_sync;
  logic [sync_stages-1:0] data_sync;
  logic [sync_stages-1:0] valid_sync;
  logic                   clk_hist;
  logic                   valid_hist;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      clk_sync   <= '0;
      data_sync  <= '0;
      valid_sync <= '1;
      clk_hist   <= 1'b0;
      valid_hist <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[sync_stages-2:0], serial_clk};
      data_sync  <= {data_sync[sync_stages-2:0], serial_in};
      valid_sync <= {valid_sync[sync_stages-2:0], serial_valid};
      clk_hist   <= clk_sync[sync_stages-1];
      valid_hist <= valid_sync[sync_stages-1];
    end
  end

  logic clk_cur;
  logic data_cur;
  logic valid_cur;
  logic clk_fall;
  logic valid_fall;

  assign clk_cur    = clk_sync[sync_stages-1];
  assign data_cur   = data_sync[sync_stages-1];
  assign valid_cur  = valid_sync[sync_stages-1];
  assign clk_fall   = clk_hist & ~clk_cur;
  assign valid_fall = valid_hist & ~valid_cur;

  // Frame state machine
  state_t        state;
  state_t        state_n;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] bit_cnt_n;
  logic [W-1:0]  shift_reg;
  logic [W-1:0]  shift_reg_n;
  logic          err_seen;
  logic          err_seen_n;
  logic          deliver;
  logic          err_pulse;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      err_seen  <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_reg_n;
      err_seen  <= err_seen_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_reg_n = shift_reg;
    err_seen_n  = err_seen;
    deliver     = 1'b0;
    err_pulse   = 1'b0;
    case (state)
      IDLE: begin
        if (valid_fall) begin
          state_n     = SHIFT;
          bit_cnt_n   = '0;
          shift_reg_n = '0;
          err_seen_n  = 1'b0;
        end
      end
      SHIFT: begin
        // A full count wins over a frame line that rose with the last edge:
        // that bit was captured first, so the word is complete and clean.
        if (bit_cnt == CW'(W)) begin
          deliver   = 1'b1;
          bit_cnt_n = '0;
          state_n   = valid_cur ? IDLE : WAIT_END;
        end else if (clk_fall) begin
          shift_reg_n = {shift_reg[W-2:0], data_cur};
          bit_cnt_n   = bit_cnt + 1'b1;
        end else if (valid_cur) begin
          err_pulse   = 1'b1;
          bit_cnt_n   = '0;
          shift_reg_n = '0;
          state_n     = IDLE;
        end
      end
      WAIT_END: begin
        if (valid_cur) begin
          state_n = IDLE;
        end else if (clk_fall && !err_seen) begin
          err_pulse  = 1'b1;
          err_seen_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign fsm_state = state;

  // Output port: word_valid stays high until word_valid && word_ready at a
  // rising edge; word never changes while word_valid is high except in the
  // same edge that consumes it.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      word        <= '0;
      word_valid  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_error <= err_pulse;
      overrun     <= 1'b0;
      if (deliver) begin
        if (!word_valid || word_ready) begin
          word        <= shift_reg;
          word_valid  <= 1'b1;
          frame_count <= frame_count + 16'd1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Receiving end of the phase-tag serial link: accepts the gated serial clock, serial data and frame line produced by the phase-detector shift-out path.
- Oversamples all three lines in the sys_clk domain and reassembles each word.
- Presents each word on a valid/ready interface, e.g. for a FIFO or UART bridge on the capture board.
- Flags malformed frames and output overruns.

Parameters:
- phase_count_size, 16, bits per frame / output word width.
- sync_stages, 2, synchronizer flops per serial input (minimum 2).

Ports:
- sys_clk  input  1  receiver clock; must be at least 4x the serial clock frequency.
- rst  input  1  synchronous active-high reset, sampled on posedge sys_clk.
- serial_clk  input  1  gated serial clock; toggles only during a frame.
- serial_in  input  1  serial data, MSB first; changes just after each serial_clk rising edge.
- serial_valid  input  1  frame line: high when the link is idle, low for the whole frame.
- word  output  phase_count_size  received word.
- word_valid  output  1  word holds unconsumed data.
- word_ready  input  1  consumer accepts word when word_valid && word_ready.
- frame_error  output  1  one-cycle pulse on a malformed frame.
- overrun  output  1  one-cycle pulse when a completed word is dropped.
- frame_count  output  16  count of words successfully pushed to the output; wraps at 0xFFFF -> 0.

Behaviour:
- Clocking and reset:
  - Single clock domain (sys_clk) with synchronous active-high reset.
  - Reset values: word=0, word_valid=0, frame_error=0, overrun=0, frame_count=0, state=IDLE, bit_cnt=0, shift register=0.
  - Synchronizer flops reset to idle levels: clk=0, data=0, valid=1.
- Input path:
  - Each input passes through sync_stages flops, then one history flop for edge detection.
  - All three lines share identical delay, so relative timing is preserved.
- Sampling: data is captured on a detected falling edge of synced serial_clk (history=1, current=0), which is mid-bit.
- State machine (bit_cnt is log2(phase_count_size)+1 bits):
  - IDLE: on a synced serial_valid falling edge -> SHIFT with bit_cnt=0. Clock edges seen in IDLE are ignored.
  - SHIFT, on each clk falling edge: shift_reg <= {shift_reg[W-2:0], data}; bit_cnt++.
  - SHIFT, when bit_cnt reaches phase_count_size: deliver the word (see Output handshake), then -> WAIT_END.
  - SHIFT, if synced serial_valid goes high with bit_cnt < phase_count_size: pulse frame_error, discard partial data, -> IDLE.
  - WAIT_END, synced serial_valid high -> IDLE.
  - WAIT_END, any further clk falling edge: pulse frame_error once per frame, stay in WAIT_END. The already-delivered word stands.
- Output handshake:
  - Delivery with word_valid=0, or with word_valid && word_ready in the same cycle: word <= new data, word_valid=1, frame_count++.
  - Delivery with word_valid=1 && word_ready=0: new word dropped, overrun pulses 1 cycle, old word kept, frame_count unchanged.
  - word_valid clears the cycle after a handshake unless a new delivery occurs in that same cycle.
  - word is stable while word_valid=1.
- Latency: 16th serial_clk falling edge at the pin -> word_valid high after sync_stages+2 sys_clk cycles (4 cycles at default).
- Reset mid-frame: all state returns to reset values; the partial frame is lost. The next serial_valid falling edge starts a fresh frame.
- Simultaneous events:
  - serial_valid rising in the same cycle as the final clk falling edge: the bit is captured first, so the word completes with no error, then -> IDLE.
  - serial_valid falling while in WAIT_END is not possible under the protocol; if seen, it is treated as end-of-frame.

Test Plan:
- Single frame 0xA5C3, 8 sys_clk per serial bit, word_ready=1 -> word=0xA5C3, word_valid for 1 cycle, frame_count=1, no error pulses.
- Two back-to-back frames 0x0001 then 0xFFFF, word_ready=0 -> word stays 0x0001, overrun pulses once on second completion, frame_count=1.
- Frame aborted after 9 bits (serial_valid returns high) -> frame_error pulses once, word_valid stays 0; following frame 0x1234 received correctly.
- 17 clock pulses in one frame carrying 0xBEEF plus 1 extra bit -> word=0xBEEF delivered, frame_error pulses once in WAIT_END.
- rst asserted after 5 bits, then a clean frame 0x8001 -> outputs 0 during reset; after reset word=0x8001, frame_count=1.
- Completion coincident with word_ready accepting the previous word (0x1111 pending, 0x2222 completes) -> word=0x2222, word_valid held, no overrun, frame_count=2.
